uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Transmit sequencer for the UART TX path. It drains the 16-deep TX FIFO one character at a time and serializes each character onto txd as a start bit, 5-8 data bits (LSB first), an optional parity bit and 1 or 2 stop bits. Bit timing comes from an internal divisor counter. The block sits between the TX FIFO and the serial pin, and its configuration inputs are driven from the line-control and divisor registers.

Parameters:
DIV_W, 16, width of the baud divisor input and of the internal bit-period counter

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  reset, asynchronous, active-low
tx_en  input  1  allows a new character to start; never aborts a frame in progress
divisor  input  DIV_W  clocks per bit; value 0 blocks any new frame start
char_len  input  2  data bits per character: 0=5, 1=6, 2=7, 3=8
parity_en  input  1  1 = insert parity bit after data
even_par  input  1  1 = even parity, 0 = odd parity
stop2  input  1  1 = two stop bits, 0 = one stop bit
fifo_empty  input  1  TX FIFO empty flag
fifo_data  input  8  TX FIFO head data (combinational from FIFO read pointer)
fifo_pop  output  1  one-cycle pop strobe to the FIFO
txd  output  1  serial output, idle high, registered
busy  output  1  high whenever state != IDLE
tx_done  output  1  one-cycle pulse at end of the final stop bit

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, txd=1, fifo_pop=0, busy=0, tx_done=0, bit counter=0, shift register=0. Asserting reset mid-frame returns txd high immediately and drops the frame. The FIFO content is not touched.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Start condition, IDLE only: tx_en & !fifo_empty & divisor!=0.
  - In that same cycle, fifo_pop=1 (combinational, exactly one cycle) and fifo_data is captured into the shift register.
  - char_len, parity_en, even_par, stop2 and divisor are latched in that cycle.
  - Next state is START.
- Config changes during a frame have no effect until the next start.
- Each of START, each DATA bit, PARITY, STOP1 and STOP2 lasts exactly latched-divisor clocks. The bit counter counts from divisor-1 down to 0 and advances on 0.
- txd is registered: START drives 0, DATA drives shift[0] (shift right per bit), PARITY drives the parity bit, and STOP1/STOP2 drive 1.
- DATA sends char_len+5 bits. Data bits above the latched length are ignored and excluded from parity.
- Parity bit = XOR of the transmitted data bits when even_par=1, and its inversion when even_par=0.
- Transitions:
  - DATA -> PARITY if parity_en, else STOP1.
  - STOP1 -> STOP2 if stop2, else IDLE.
  - STOP2 -> IDLE.
- tx_done pulses in the last clock of the final stop bit.
- Back-to-back: the controller always spends exactly one cycle in IDLE between frames. The pop for the next character occurs in that cycle, so the inter-frame line gap is 1 clock of high.
- fifo_pop is never asserted while fifo_empty=1 or outside IDLE. There is at most one pop per frame.
- tx_en deasserted mid-frame: the current frame completes and no new start is taken.
- divisor=0 while IDLE: no start, txd stays 1, FIFO is not popped.
- Timing: frame length in clocks = divisor*(1+N+P+S) for N data bits, P parity bits (0/1) and S stop bits (1/2).

Test Plan:
1. 8N1, divisor=4, FIFO holds 0xA5, tx_en=1:
   - fifo_pop for 1 cycle at T0.
   - txd from T1 = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks.
   - tx_done at T40, busy low at T41.
2. 7E1, divisor=2, char_len=2, data 0x41:
   - data bits 1,0,0,0,0,0,1, then parity 0, then stop 1.
   - frame is 20 clocks, and bit 7 of the data is not sent.
3. 8O2, divisor=3, data 0xFF:
   - parity bit=1, two stop bits.
   - frame is 36 clocks, and tx_done arrives 36 clocks after the pop.
4. Back-to-back 0x00 then 0xFF, 8N1, divisor=1:
   - frame 1 occupies 10 clocks, then 1 idle clock with the second pop, then frame 2.
   - exactly 2 pops total, and fifo_empty=1 afterwards causes no pop.
5. tx_en dropped mid-data of frame 1 with 2 chars queued:
   - frame 1 completes.
   - no second pop, txd=1, busy=0.
6. rstn asserted asynchronously mid-DATA:
   - txd=1 and busy=0 before the next clk edge.
   - after release with FIFO non-empty and divisor=0, no pop.
   - setting divisor=4 then starts a normal frame.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// FIFO-side handshake bundle for the UART TX sequencer.
// master: controller (pops), slave: FIFO (supplies head data/empty).
interface uart_tx_ctrl_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_pop;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_pop
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_pop
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX sequencer: pops one char from the TX FIFO and sends
// start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Ports: clk, rstn (async low), tx_en, divisor, char_len,
// parity_en, even_par, stop2, fifo (master), txd, busy, tx_done.
module uart_tx_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       char_len,
  input  logic             parity_en,
  input  logic             even_par,
  input  logic             stop2,
  uart_tx_ctrl_if.master   fifo,
  output logic             txd,
  output logic             busy,
  output logic             tx_done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       last_q, last_d;
  logic             pen_q, pen_d;
  logic             par_q, par_d;
  logic             stp2_q, stp2_d;
  logic             txd_q, txd_d;
  logic             pop;
  logic             start;
  logic             tick;
  logic [7:0]       mask;

  // Keeps only the bits that will actually be sent.
  assign mask  = 8'hFF >> (3'd3 - {1'b0, char_len});
  assign start = tx_en & ~fifo.fifo_empty
               & (divisor != '0);
  assign tick  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    last_d  = last_q;
    pen_d   = pen_q;
    par_d   = par_q;
    stp2_d  = stp2_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        cnt_d = '0;
        if (start) begin
          pop     = 1'b1;
          shift_d = fifo.fifo_data;
          div_d   = divisor;
          cnt_d   = divisor - ONE;
          last_d  = {1'b0, char_len} + 3'd4;
          pen_d   = parity_en;
          stp2_d  = stop2;
          par_d   = ^(fifo.fifo_data & mask)
                  ^ ~even_par;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        cnt_d = tick ? div_q - ONE : cnt_q - ONE;
        if (tick) begin
          bit_d   = '0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = tick ? div_q - ONE : cnt_q - ONE;
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == last_q) begin
            txd_d   = pen_q ? par_q : 1'b1;
            state_d = pen_q ? PARITY : STOP1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        cnt_d = tick ? div_q - ONE : cnt_q - ONE;
        if (tick) begin
          txd_d   = 1'b1;
          state_d = STOP1;
        end
      end
      STOP1: begin
        cnt_d = tick ? div_q - ONE : cnt_q - ONE;
        if (tick) begin
          txd_d   = 1'b1;
          state_d = stp2_q ? STOP2 : IDLE;
        end
      end
      STOP2: begin
        cnt_d = tick ? div_q - ONE : cnt_q - ONE;
        if (tick) begin
          txd_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      last_q  <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      stp2_q  <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      stp2_q  <= stp2_d;
      txd_q   <= txd_d;
    end
  end

  assign fifo.fifo_pop = pop;
  assign txd     = txd_q;
  assign busy    = (state_q != IDLE);
  assign tx_done = tick
                 & (((state_q == STOP1) & ~stp2_q)
                 | (state_q == STOP2));

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: table frames, random
// frames vs. a bit-list model, and multi-cycle corner sequences.
module tb_uart_tx_ctrl;

  logic        clk;
  logic        rstn;
  logic        tx_en;
  logic [15:0] divisor;
  logic [1:0]  char_len;
  logic        parity_en;
  logic        even_par;
  logic        stop2;
  logic        txd;
  logic        busy;
  logic        tx_done;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(.DIV_W(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .tx_en     (tx_en),
    .divisor   (divisor),
    .char_len  (char_len),
    .parity_en (parity_en),
    .even_par  (even_par),
    .stop2     (stop2),
    .fifo      (bus.master),
    .txd       (txd),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int bad_pop = 0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.fifo_data  = mem[rd_ptr % 16];

  always @(posedge clk) begin
    if (bus.fifo_pop) begin
      if (bus.fifo_empty || busy) bad_pop <= bad_pop + 1;
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 16] = d;
    wr_ptr++;
  endtask

  // Line bits of one frame, one entry per bit period.
  function automatic int build(input logic [7:0] d, input int len,
                               input bit pe, input bit ev,
                               input bit s2, output bit b[12]);
    int n;
    int k;
    int ones;
    n = len + 5;
    k = 0;
    ones = 0;
    for (int i = 0; i < 12; i++) b[i] = 1'b1;
    b[k] = 1'b0;
    k++;
    for (int i = 0; i < n; i++) begin
      b[k] = d[i];
      k++;
      ones += int'(d[i]);
    end
    if (pe) begin
      b[k] = ev ? bit'(ones % 2) : bit'(1 - ones % 2);
      k++;
    end
    b[k] = 1'b1;
    k++;
    if (s2) begin
      b[k] = 1'b1;
      k++;
    end
    return k;
  endfunction

  task automatic set_cfg(input int len, input bit pe,
                         input bit ev, input bit s2,
                         input int div);
    char_len  = 2'(len);
    parity_en = pe;
    even_par  = ev;
    stop2     = s2;
    divisor   = 16'(div);
  endtask

  task automatic wait_pop(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.fifo_pop) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Waits for the pop, then checks every clock of the frame.
  task automatic check_frame(input string nm, input logic [7:0] d,
                             input int len, input bit pe,
                             input bit ev, input bit s2,
                             input int div, input int exp_len,
                             input bit exp_par, input bit drop);
    bit b[12];
    int nb;
    int L;
    int werr;
    int done_at;
    int par_seen;
    int busy_after;
    bit got;
    nb = build(d, len, pe, ev, s2, b);
    L = nb * div;
    wait_pop(got);
    check({nm, " pop"}, int'(got), 1);
    if (!got) return;
    werr = 0;
    done_at = -1;
    par_seen = -1;
    busy_after = -1;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      #1;
      if (k == 1 && drop) tx_en = 1'b0;
      if (k <= L && txd !== b[(k - 1) / div]) werr++;
      if (tx_done === 1'b1 && done_at < 0) done_at = k;
      if (pe && k == (len + 6) * div + 1) par_seen = int'(txd);
      if (k == L + 1) busy_after = int'(busy);
    end
    check({nm, " wave_err"}, werr, 0);
    check({nm, " done_at"}, done_at, exp_len);
    check({nm, " busy_after"}, busy_after, 0);
    if (pe) check({nm, " parity"}, par_seen, int'(exp_par));
  endtask

  typedef struct {
    logic [7:0] data;
    int         len;
    bit         pe;
    bit         ev;
    bit         s2;
    int         div;
    int         exp_len;
    bit         exp_par;
  } vec_t;

  vec_t tbl[5];

  initial begin
    bit b0[12];
    bit b1[12];
    bit seq[24];
    bit got;
    int n0;
    int n1;
    int base;
    int werr;
    int ndone;
    int pop11;
    int gone;

    tbl[0] = '{8'hA5, 3, 1'b0, 1'b0, 1'b0, 4, 40, 1'b0};
    tbl[1] = '{8'h41, 2, 1'b1, 1'b1, 1'b0, 2, 20, 1'b0};
    tbl[2] = '{8'hC1, 2, 1'b1, 1'b1, 1'b0, 2, 20, 1'b0};
    tbl[3] = '{8'hFF, 3, 1'b1, 1'b0, 1'b1, 3, 36, 1'b1};
    tbl[4] = '{8'h13, 0, 1'b1, 1'b1, 1'b1, 1, 9, 1'b1};

    rstn = 1'b0;
    tx_en = 1'b0;
    set_cfg(3, 0, 0, 0, 4);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst txd", int'(txd), 1);
    check("rst busy", int'(busy), 0);
    check("rst pop", int'(bus.fifo_pop), 0);
    check("rst done", int'(tx_done), 0);
    rstn = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      set_cfg(tbl[i].len, tbl[i].pe, tbl[i].ev,
              tbl[i].s2, tbl[i].div);
      push(tbl[i].data);
      tx_en = 1'b1;
      check_frame($sformatf("tbl%0d", i), tbl[i].data,
                  tbl[i].len, tbl[i].pe, tbl[i].ev, tbl[i].s2,
                  tbl[i].div, tbl[i].exp_len, tbl[i].exp_par, 1);
    end

    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      int len;
      int div;
      bit pe;
      bit ev;
      bit s2;
      bit rb[12];
      int nb;
      d   = 8'($urandom);
      len = int'($urandom_range(0, 3));
      pe  = 1'($urandom);
      ev  = 1'($urandom);
      s2  = 1'($urandom);
      div = int'($urandom_range(1, 4));
      nb  = build(d, len, pe, ev, s2, rb);
      set_cfg(len, pe, ev, s2, div);
      push(d);
      tx_en = 1'b1;
      check_frame($sformatf("rnd%0d", i), d, len, pe, ev, s2, div,
                  div * (1 + len + 5 + int'(pe) + 1 + int'(s2)),
                  rb[len + 6], 1);
    end

    // Back-to-back 0x00 then 0xFF at one clock per bit.
    set_cfg(3, 0, 0, 0, 1);
    push(8'h00);
    push(8'hFF);
    n0 = build(8'h00, 3, 0, 0, 0, b0);
    n1 = build(8'hFF, 3, 0, 0, 0, b1);
    for (int i = 0; i < 24; i++) seq[i] = 1'b1;
    for (int i = 0; i < n0; i++) seq[i] = b0[i];
    for (int i = 0; i < n1; i++) seq[n0 + 1 + i] = b1[i];
    base = pop_cnt;
    tx_en = 1'b1;
    wait_pop(got);
    check("b2b first pop", int'(got), 1);
    werr = 0;
    ndone = 0;
    pop11 = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      #1;
      if (txd !== seq[k - 1]) werr++;
      if (tx_done === 1'b1) ndone++;
      if (k == 11) pop11 = int'(bus.fifo_pop);
    end
    check("b2b wave_err", werr, 0);
    check("b2b pop in gap", pop11, 1);
    check("b2b done pulses", ndone, 2);
    check("b2b pops", pop_cnt - base, 2);
    repeat (4) @(negedge clk);
    #1;
    check("b2b empty no pop", pop_cnt - base, 2);
    tx_en = 1'b0;

    // tx_en dropped mid-data with two chars queued.
    set_cfg(3, 0, 0, 0, 2);
    push(8'h3C);
    push(8'h5A);
    base = pop_cnt;
    tx_en = 1'b1;
    wait_pop(got);
    check("drop pop", int'(got), 1);
    repeat (8) @(negedge clk);
    #1;
    tx_en = 1'b0;
    gone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        gone = 1;
        break;
      end
    end
    check("drop frame ends", gone, 1);
    repeat (4) @(negedge clk);
    #1;
    check("drop pops", pop_cnt - base, 1);
    check("drop txd", int'(txd), 1);
    check("drop busy", int'(busy), 0);

    // Async reset mid-DATA, then divisor 0 blocks, then 4 starts.
    push(8'h96);
    set_cfg(3, 0, 0, 0, 4);
    tx_en = 1'b1;
    wait_pop(got);
    check("rst6 pop", int'(got), 1);
    repeat (8) @(negedge clk);
    #1;
    check("rst6 busy pre", int'(busy), 1);
    rstn = 1'b0;
    #1;
    check("rst6 txd", int'(txd), 1);
    check("rst6 busy", int'(busy), 0);
    divisor = 16'd0;
    @(negedge clk);
    rstn = 1'b1;
    base = pop_cnt;
    repeat (6) @(negedge clk);
    #1;
    check("div0 no pop", pop_cnt - base, 0);
    check("div0 txd", int'(txd), 1);
    divisor = 16'd4;
    check_frame("rst6 frame", 8'h96, 3, 0, 0, 0, 4, 40, 1'b0, 1);

    check("illegal pops", bad_pop, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
